multi_transition_detector: RTL

Parametrised multi-channel transition detector and coincidence monitor. It samples CH single-bit inputs every clock and flags rising, falling or both edges according to a runtime mode. It keeps a per-channel edge counter that either saturates or wraps, and pulses a detect flag when every enabled channel has produced an edge within a programmable window of WIN clocks. It is the generalised successor to the two-input transition detector and sits between input conditioning and the event/interrupt logic.

---
 rtl/multi_transition_detector.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/multi_transition_detector.sv
// multi_transition_detector
// Multi-channel edge detector with per-channel edge counters and a
// windowed coincidence monitor. det_out pulses for one clock once every
// enabled channel has produced an edge within WIN clocks.

module multi_transition_detector #(
    parameter int CH    = 2,
    parameter int CNT_W = 2,
    parameter int WIN   = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CH-1:0]       in,
    input  logic [1:0]          mode,
    input  logic [CH-1:0]       mask,
    input  logic                sat_en,
    input  logic                clr,
    output logic [1:0]          ps,
    output logic [1:0]          ns,
    output logic [CH-1:0]       edge_out,
    output logic [CH*CNT_W-1:0] cnt,
    output logic                det_out
);

    localparam logic [1:0] INIT   = 2'b00;
    localparam logic [1:0] IDLE   = 2'b01;
    localparam logic [1:0] WINDOW = 2'b10;
    localparam logic [1:0] DETECT = 2'b11;

    // Window counter must hold WIN-1; sized so WIN=1 still gets one bit.
    localparam int              WC_W     = (WIN > 1) ? $clog2(WIN) : 1;
    localparam logic [WC_W-1:0] WIN_LOAD = WC_W'(WIN - 1);
    localparam logic [WC_W-1:0] WC_ONE   = WC_W'(1);

    logic [CH-1:0]                 in_d;
    logic [CH-1:0]                 edge_raw;
    logic [CH-1:0]                 e;
    logic [CH-1:0]                 m;
    logic [CH-1:0]                 seen;
    logic [CH-1:0]                 seen_nxt;
    logic [WC_W-1:0]               wcnt;
    logic [WC_W-1:0]               wcnt_nxt;
    logic                          complete;
    logic [CH-1:0][CNT_W-1:0]      cnt_r;

    // Edge selection; the reserved mode code behaves as "both".
    always_comb begin
        case (mode)
            2'b00:   edge_raw = in & ~in_d;
            2'b01:   edge_raw = ~in & in_d;
            default: edge_raw = in ^ in_d;
        endcase
    end

    // in_d holds no valid history in INIT, so no edge may be reported there.
    assign e        = (ps == INIT) ? '0 : edge_raw;
    assign m        = e & mask;
    assign complete = (((seen | m) & mask) == mask) && (mask != '0);

    // Next-state, seen-set and window-count decode; clr overrides all.
    always_comb begin
        ns       = ps;
        seen_nxt = seen;
        wcnt_nxt = wcnt;
        case (ps)
            INIT: begin
                ns       = IDLE;
                seen_nxt = '0;
                wcnt_nxt = '0;
            end
            IDLE: begin
                if (complete) begin
                    ns       = DETECT;
                    seen_nxt = '0;
                end else if ((m != '0) && (WIN > 1)) begin
                    ns       = WINDOW;
                    seen_nxt = m;
                    wcnt_nxt = WIN_LOAD;
                end else begin
                    seen_nxt = '0;
                end
            end
            WINDOW: begin
                if (complete) begin
                    ns       = DETECT;
                    seen_nxt = '0;
                end else if (wcnt == WC_ONE) begin
                    ns       = IDLE;
                    seen_nxt = '0;
                end else begin
                    seen_nxt = seen | m;
                    wcnt_nxt = wcnt - WC_ONE;
                end
            end
            default: begin
                // DETECT: always one cycle, new edges do not open a window.
                ns       = IDLE;
                seen_nxt = '0;
            end
        endcase
        if (clr) begin
            ns       = (ps == INIT) ? INIT : IDLE;
            seen_nxt = '0;
            wcnt_nxt = '0;
        end
    end

    // Input history, edge flags and FSM state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_d     <= '0;
            edge_out <= '0;
            ps       <= INIT;
            seen     <= '0;
            wcnt     <= '0;
        end else begin
            in_d     <= in;
            edge_out <= e;
            ps       <= ns;
            seen     <= seen_nxt;
            wcnt     <= wcnt_nxt;
        end
    end

    // Per-channel edge counters; saturate or wrap at all-ones.
    for (genvar i = 0; i < CH; i++) begin : g_cnt
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_r[i] <= '0;
            end else if (clr) begin
                cnt_r[i] <= '0;
            end else if (e[i]) begin
                if (&cnt_r[i])
                    cnt_r[i] <= sat_en ? cnt_r[i] : '0;
                else
                    cnt_r[i] <= cnt_r[i] + CNT_W'(1);
            end
        end
    end

    assign cnt     = cnt_r;
    assign det_out = (ps == DETECT);

endmodule
